// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Boot-time writer for the instruction memory. A session starts with i_start
// and receives a little-endian 32-bit word count (4 header bytes). That header
// is followed by the payload, four bytes per instruction word. Each assembled
// word is written once on the instruction-memory port. The CPU is held in
// reset until a complete, valid image has been written.
//
// Optional feature (macro INST_LOADER_CSUM_EN):
//   When the macro is defined, a trailer byte follows the payload. The
//   trailer must equal the modulo-256 sum of all payload bytes. A match ends
//   in DONE; a mismatch ends in ERR. When the macro is undefined there is no
//   trailer and no sum logic.
//
// Parameters:
//   MEM_SIZE    instruction-memory depth in words; largest accepted length
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_start     single-cycle pulse, begins a session (ignored while busy)
//   i_rx_data   incoming byte
//   i_rx_valid  i_rx_data valid
//   o_rx_ready  byte accepted on this edge when i_rx_valid is also high
//   o_we        instruction-memory write strobe, one cycle per word
//   o_waddr     byte address of the word being written
//   o_wdata     word being written
//   o_busy      session in progress
//   o_done      image loaded successfully
//   o_err       session aborted
//   o_cpu_hold  1 = keep CPU in reset
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module inst_loader #(
    parameter int MEM_SIZE = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic                   o_rx_ready,
    output logic                   o_we,
    output logic [`XLEN-1:0]       o_waddr,
    output logic [`INST_WIDTH-1:0] o_wdata,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_cpu_hold
);

    localparam int XW = `XLEN;
    localparam int IW = `INST_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef INST_LOADER_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    // State entered once the last word has been written (or on a zero length).
`ifdef INST_LOADER_CSUM_EN
    localparam state_t S_FINAL = S_CSUM;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t        state_q,    state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   len_q,      len_d;
    logic [31:0]   word_idx_q, word_idx_d;
    logic [IW-1:0] asm_q,      asm_d;
`ifdef INST_LOADER_CSUM_EN
    logic [7:0]    sum_q,      sum_d;
`endif

    logic          accept;
    logic [31:0]   hdr_len;

    // Registered-state decodes only: no combinational path from inputs.
`ifdef INST_LOADER_CSUM_EN
    assign o_rx_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign o_busy     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE)
                     || (state_q == S_CSUM);
`else
    assign o_rx_ready = (state_q == S_HDR) || (state_q == S_DATA);
    assign o_busy     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE);
`endif
    assign o_we       = (state_q == S_WRITE);
    assign o_waddr    = (state_q == S_WRITE) ? XW'(word_idx_q << 2) : '0;
    assign o_wdata    = (state_q == S_WRITE) ? asm_q : '0;
    assign o_done     = (state_q == S_DONE);
    assign o_err      = (state_q == S_ERR);
    assign o_cpu_hold = (state_q != S_DONE);

    assign accept  = i_rx_valid && o_rx_ready;
    // Full length as it will be once the 4th header byte (MSB) is taken.
    assign hdr_len = {i_rx_data, len_q[23:0]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
`ifdef INST_LOADER_CSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_d    = S_HDR;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    word_idx_d = '0;
                    asm_d      = '0;
`ifdef INST_LOADER_CSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            S_HDR: begin
                if (accept) begin
                    len_d[8*byte_cnt_q +: 8] = i_rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (hdr_len == 32'd0)
                            state_d = S_FINAL;
                        else if (hdr_len > 32'(MEM_SIZE))
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d[8*byte_cnt_q +: 8] = i_rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CSUM_EN
                    sum_d = sum_q + i_rx_data;
`endif
                    if (byte_cnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 32'd1;
                if (word_idx_q + 32'd1 == len_q)
                    state_d = S_FINAL;
                else
                    state_d = S_DATA;
            end
`ifdef INST_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept)
                    state_d = (i_rx_data == sum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            asm_q      <= '0;
`ifdef INST_LOADER_CSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
`ifdef INST_LOADER_CSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule
